// File: rtl/sdio_evt_pkg.sv
// Shared types and defaults for the SDIO toggle-encoded event crossing transmitter.
// Channel FSM encoding and default channel/counter sizing live here.
package sdio_evt_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int CNT_W_DEF  = 3;

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } evt_state_e;

endpackage

// File: rtl/sdio_evt_tgl_ch.sv
// One event channel: turns sys_clk pulses into toggles on evt_tgl, waits for the
// far-domain echo, and queues events that arrive while a crossing is in flight.
module sdio_evt_tgl_ch
   import sdio_evt_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic             rst,
   input  logic             sys_clk,
   input  logic             evt_p,
   input  logic             flush,
   input  logic             ack_tgl,
   output logic             evt_tgl,
   output logic             busy,
   output logic             ovf_p,
   output logic [CNT_W-1:0] pend_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   evt_state_e       state_q, state_d;
   logic             tgl_q, tgl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             ack_s1_q, ack_s1_d;
   logic             ack_s2_q, ack_s2_d;
   logic             done;
   logic             evt_take;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         tgl_q    <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgl_q    <= tgl_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         ack_s1_q <= ack_s1_d;
         ack_s2_q <= ack_s2_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tgl_d    = tgl_q;
      cnt_d    = cnt_q;
      ovf_d    = 1'b0;
      ack_s1_d = ack_tgl;
      ack_s2_d = ack_s1_q;
      // A flush discards a coincident event except when idle, where it issues directly.
      evt_take = evt_p && !flush;
      done     = (state_q == WAIT_ACK) && (ack_s2_q == tgl_q);

      unique case (state_q)
         IDLE: begin
            if (evt_p) begin
               tgl_d   = ~tgl_q;
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (done) begin
               // A new event on the completion cycle replaces the queue pop, so the count holds.
               if (evt_take) begin
                  tgl_d = ~tgl_q;
               end else if (cnt_q != '0) begin
                  tgl_d = ~tgl_q;
                  cnt_d = cnt_q - CNT_ONE;
               end else begin
                  state_d = IDLE;
               end
            end else if (evt_take) begin
               if (cnt_q == CNT_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush only empties the queue; the toggle already on the wire is left to complete.
      if (flush) begin
         cnt_d = '0;
      end
   end

   assign evt_tgl  = tgl_q;
   assign busy     = (state_q == WAIT_ACK);
   assign ovf_p    = ovf_q;
   assign pend_cnt = cnt_q;

endmodule

// File: rtl/sdio_evt_tgl_tx.sv
// Multi-channel sys_clk-side transmitter for toggle-encoded event crossings.
// Each channel is independent; pend_cnt is packed channel i at [i*CNT_W +: CNT_W].
module sdio_evt_tgl_tx
   import sdio_evt_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int CNT_W  = CNT_W_DEF
)
(
   input  logic                    rst,
   input  logic                    sys_clk,
   input  logic [NUM_CH-1:0]       evt_p,
   input  logic [NUM_CH-1:0]       flush,
   input  logic [NUM_CH-1:0]       ack_tgl,
   output logic [NUM_CH-1:0]       evt_tgl,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       ovf_p,
   output logic [NUM_CH*CNT_W-1:0] pend_cnt
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         sdio_evt_tgl_ch #(
            .CNT_W (CNT_W)
         ) u_ch (
            .rst      (rst),
            .sys_clk  (sys_clk),
            .evt_p    (evt_p[gi]),
            .flush    (flush[gi]),
            .ack_tgl  (ack_tgl[gi]),
            .evt_tgl  (evt_tgl[gi]),
            .busy     (busy[gi]),
            .ovf_p    (ovf_p[gi]),
            .pend_cnt (pend_cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

endmodule
